// File: rtl/dcpu_uart.sv
// dcpu_uart: memory-mapped 8N1 UART with TX/RX FIFOs, programmable baud divider and level interrupt.
// Optional loopback path is enabled by defining DCPU_UART_LOOPBACK_EN.
// Revision: 1.0
`default_nettype none

module dcpu_uart_fifo #(
  parameter int AW = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_push,
  input  logic [7:0] i_wdata,
  input  logic       i_pop,
  output logic [7:0] o_rdata,
  output logic       o_empty,
  output logic       o_full
);
  localparam int DEPTH = 1 << AW;

  logic [7:0]  mem_q [DEPTH];
  logic [7:0]  mem_d [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic        do_push, do_pop;

  assign o_empty = (wr_q == rd_q);
  assign o_full  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
  assign o_rdata = mem_q[rd_q[AW-1:0]];

  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign do_pop  = i_pop & ~o_empty;
  assign do_push = i_push & (~o_full | do_pop);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (do_push) begin
      mem_d[wr_q[AW-1:0]] = i_wdata;
      wr_d = wr_q + 1'b1;
    end
    if (do_pop) rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge i_clk) mem_q <= mem_d;
endmodule

module dcpu_uart #(
  parameter logic [15:0] BAUD_DIV_DEFAULT = 16'd103,
  parameter int          FIFO_AW          = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cs,
  input  logic        i_we,
  input  logic [1:0]  i_addr,
  input  logic [15:0] i_dat,
  output logic [15:0] o_dat,
  output logic        o_ack,
  output logic        o_int,
  input  logic        i_rx,
  output logic        o_tx
);
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_e;

  logic        ack_q, ack_d, int_q, int_d;
  logic [15:0] dat_q, dat_d, baud_q, baud_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        ovr_q, ovr_d, ferr_q, ferr_d;

  logic        acc, wr_data, rd_data, wr_stat;
  logic [15:0] rd_mux;

  logic [7:0]  tx_rdata, rx_rdata;
  logic        tx_empty, tx_full, rx_empty, rx_full;
  logic        tx_pop, rx_push, tx_idle, tx_bit, rx_line;

  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_per_q, tx_per_d;
  logic [2:0]  tx_idx_q, tx_idx_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_bit_end, tx_load;

  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_per_q, rx_per_d, rx_half;
  logic [2:0]  rx_idx_q, rx_idx_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic        rx_ovr_set, rx_ferr_set;

  assign acc     = i_cs & ~ack_q;
  assign wr_data = acc & i_we  & (i_addr == 2'd0);
  assign rd_data = acc & ~i_we & (i_addr == 2'd0);
  assign wr_stat = acc & i_we  & (i_addr == 2'd1);
  assign tx_idle = tx_empty & (tx_state_q == TX_IDLE);

  dcpu_uart_fifo #(.AW(FIFO_AW)) u_tx_fifo (
    .i_clk(i_clk), .i_reset(i_reset), .i_push(wr_data), .i_wdata(i_dat[7:0]),
    .i_pop(tx_pop), .o_rdata(tx_rdata), .o_empty(tx_empty), .o_full(tx_full)
  );

  dcpu_uart_fifo #(.AW(FIFO_AW)) u_rx_fifo (
    .i_clk(i_clk), .i_reset(i_reset), .i_push(rx_push), .i_wdata(rx_shift_q),
    .i_pop(rd_data), .o_rdata(rx_rdata), .o_empty(rx_empty), .o_full(rx_full)
  );

`ifdef DCPU_UART_LOOPBACK_EN
  assign rx_line = ctrl_q[2] ? tx_bit : i_rx;
  assign o_tx    = ctrl_q[2] ? 1'b1 : tx_bit;
`else
  assign rx_line = i_rx;
  assign o_tx    = tx_bit;
`endif

  assign o_ack = ack_q;
  assign o_dat = dat_q;
  assign o_int = int_q;

  always_comb begin
    rd_mux = 16'h0000;
    case (i_addr)
      2'd0: rd_mux = rx_empty ? 16'h0000 : {8'h00, rx_rdata};
      2'd1: rd_mux = {11'd0, ferr_q, ovr_q, tx_idle, tx_full, ~rx_empty};
      2'd2: rd_mux = {13'd0, ctrl_q};
      default: rd_mux = baud_q;
    endcase
  end

  always_comb begin
    ack_d  = acc;
    dat_d  = (acc && !i_we) ? rd_mux : 16'h0000;
    ctrl_d = ctrl_q;
    baud_d = baud_q;
    if (acc && i_we && i_addr == 2'd2) begin
`ifdef DCPU_UART_LOOPBACK_EN
      ctrl_d = i_dat[2:0];
`else
      ctrl_d = {1'b0, i_dat[1:0]};
`endif
    end
    if (acc && i_we && i_addr == 2'd3) baud_d = i_dat;
    // Set beats a simultaneous write-one-to-clear.
    ovr_d  = (ovr_q  & ~(wr_stat & i_dat[3])) | rx_ovr_set;
    ferr_d = (ferr_q & ~(wr_stat & i_dat[4])) | rx_ferr_set;
    int_d  = (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_idle);
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_per_d   = tx_per_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    tx_load    = 1'b0;
    tx_bit_end = (tx_cnt_q == tx_per_q);
    if (tx_state_q != TX_IDLE) begin
      if (tx_bit_end) begin
        tx_cnt_d = 16'd0;
        tx_per_d = baud_q;
      end else begin
        tx_cnt_d = tx_cnt_q + 16'd1;
      end
    end
    case (tx_state_q)
      TX_IDLE:  if (!tx_empty) tx_load = 1'b1;
      TX_START: if (tx_bit_end) begin
        tx_state_d = TX_DATA;
        tx_idx_d   = 3'd0;
      end
      TX_DATA:  if (tx_bit_end) begin
        tx_idx_d = tx_idx_q + 3'd1;
        if (tx_idx_q == 3'd7) tx_state_d = TX_STOP;
      end
      default:  if (tx_bit_end) begin
        if (!tx_empty) tx_load = 1'b1;
        else           tx_state_d = TX_IDLE;
      end
    endcase
    // Loading from STOP chains frames with no idle gap between them.
    if (tx_load) begin
      tx_pop     = 1'b1;
      tx_shift_d = tx_rdata;
      tx_state_d = TX_START;
      tx_cnt_d   = 16'd0;
      tx_per_d   = baud_q;
    end
  end

  always_comb begin
    tx_bit = 1'b1;
    case (tx_state_q)
      TX_START: tx_bit = 1'b0;
      TX_DATA:  tx_bit = tx_shift_q[tx_idx_q];
      default:  tx_bit = 1'b1;
    endcase
  end

  assign rx_half = 16'(({1'b0, rx_per_q} + 17'd1) >> 1);

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q + 16'd1;
    rx_per_d    = rx_per_q;
    rx_idx_d    = rx_idx_q;
    rx_shift_d  = rx_shift_q;
    rx_push     = 1'b0;
    rx_ovr_set  = 1'b0;
    rx_ferr_set = 1'b0;
    case (rx_state_q)
      RX_IDLE: if (rx_prev_q && !rx_s2_q) begin
        // The edge is seen one clock after the line fell, so counting starts at 1.
        rx_state_d = RX_START;
        rx_cnt_d   = 16'd1;
        rx_per_d   = baud_q;
      end
      RX_START: if (rx_cnt_q >= rx_half) begin
        rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        rx_cnt_d   = 16'd0;
        rx_idx_d   = 3'd0;
        rx_per_d   = baud_q;
      end
      RX_DATA: if (rx_cnt_q == rx_per_q) begin
        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
        rx_idx_d   = rx_idx_q + 3'd1;
        rx_cnt_d   = 16'd0;
        rx_per_d   = baud_q;
        if (rx_idx_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_cnt_q == rx_per_q) begin
        rx_cnt_d = 16'd0;
        rx_per_d = baud_q;
        if (rx_s2_q) begin
          rx_push    = 1'b1;
          rx_ovr_set = rx_full & ~rd_data;
          rx_state_d = RX_IDLE;
        end else begin
          rx_ferr_set = 1'b1;
          rx_state_d  = RX_WAIT;
        end
      end
      default: if (rx_s2_q) rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ack_q      <= 1'b0;
      dat_q      <= 16'h0000;
      int_q      <= 1'b0;
      ctrl_q     <= 3'd0;
      baud_q     <= BAUD_DIV_DEFAULT;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= 16'd0;
      tx_per_q   <= BAUD_DIV_DEFAULT;
      tx_idx_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= 16'd0;
      rx_per_q   <= BAUD_DIV_DEFAULT;
      rx_idx_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      int_q      <= int_d;
      ctrl_q     <= ctrl_d;
      baud_q     <= baud_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_per_q   <= tx_per_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_per_q   <= rx_per_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_s1_q    <= rx_line;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_dcpu_uart.sv
// tb_dcpu_uart: randomized self-checking bench for dcpu_uart against a frame/queue level model.
`default_nettype none

module tb_dcpu_uart;
  logic        i_clk = 1'b0;
  logic        i_reset, i_cs, i_we, i_rx;
  logic [1:0]  i_addr;
  logic [15:0] i_dat, o_dat;
  logic        o_ack, o_int, o_tx;
  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  dcpu_uart dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_cs(i_cs), .i_we(i_we), .i_addr(i_addr),
    .i_dat(i_dat), .o_dat(o_dat), .o_ack(o_ack), .o_int(o_int), .i_rx(i_rx), .o_tx(o_tx)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic bus(input logic we, input logic [1:0] a, input logic [15:0] wd,
                     output logic [15:0] rd);
    i_cs = 1'b1; i_we = we; i_addr = a; i_dat = wd;
    tick();
    rd = o_dat;
    i_cs = 1'b0; i_we = 1'b0;
    tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    logic [15:0] x;
    bus(1'b1, a, d, x);
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] d);
    bus(1'b0, a, 16'h0000, d);
  endtask

  task automatic send_rx(input logic [7:0] d, input int b, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int j = 0; j < 10; j++) begin
      i_rx = f[j];
      repeat (b + 1) tick();
    end
    i_rx = 1'b1;
    repeat (2 * (b + 1) + 4) tick();
  endtask

  task automatic test_reset();
    logic [15:0] v;
    i_reset = 1'b1; i_cs = 1'b0; i_we = 1'b0; i_addr = 2'd0; i_dat = 16'h0; i_rx = 1'b1;
    repeat (3) tick();
    i_reset = 1'b0;
    checks++; if (o_tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", o_tx); end
    checks++; if (o_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", o_ack); end
    checks++; if (o_dat !== 16'h0) begin errors++; $display("FAIL reset_dat got %h want 0", o_dat); end
    checks++; if (o_int !== 1'b0) begin errors++; $display("FAIL reset_int got %b want 0", o_int); end
    rd(2'd1, v);
    checks++; if (v !== 16'h0004) begin errors++; $display("FAIL reset_status got %h want 0004", v); end
    rd(2'd2, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL reset_ctrl got %h want 0000", v); end
    rd(2'd3, v);
    checks++; if (v !== 16'd103) begin errors++; $display("FAIL reset_baud got %h want 0067", v); end
    rd(2'd0, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL reset_data got %h want 0000", v); end
  endtask

  task automatic test_back_to_back();
    logic want;
    i_cs = 1'b1; i_we = 1'b0; i_addr = 2'd1;
    for (int k = 0; k < 8; k++) begin
      tick();
      want = (k % 2 == 0);
      checks++;
      if (o_ack !== want || o_dat !== (want ? 16'h0004 : 16'h0000)) begin
        errors++; $display("FAIL b2b_ack cyc %0d got ack %b dat %h want ack %b", k, o_ack, o_dat, want);
      end
    end
    i_cs = 1'b0;
    tick();
  endtask

  task automatic test_ctrl_baud();
    logic [15:0] v, r, want;
    wr(2'd2, 16'hFFFF);
    rd(2'd2, v);
`ifdef DCPU_UART_LOOPBACK_EN
    want = 16'h0007;
`else
    want = 16'h0003;
`endif
    checks++; if (v !== want) begin errors++; $display("FAIL ctrl_rw got %h want %h", v, want); end
    wr(2'd2, 16'h0000);
    r = 16'($urandom);
    wr(2'd3, r);
    rd(2'd3, v);
    checks++; if (v !== r) begin errors++; $display("FAIL baud_rw got %h want %h", v, r); end
  endtask

  task automatic test_tx_pattern();
    logic [9:0]  f;
    logic [15:0] v;
    f = {1'b1, 8'h55, 1'b0};
    wr(2'd3, 16'd3);
    wr(2'd0, 16'h0055);
    for (int k = 0; k < 40; k++) begin
      checks++;
      if (o_tx !== f[k / 4]) begin errors++; $display("FAIL tx_wave clk %0d got %b want %b", k, o_tx, f[k / 4]); end
      tick();
    end
    rd(2'd1, v);
    checks++; if (v !== 16'h0004) begin errors++; $display("FAIL tx_idle_after got %h want 0004", v); end
  endtask

  task automatic decode_tx(input int b, input logic [7:0] exp_q[$]);
    logic [9:0] f;
    int w;
    for (int i = 0; i < exp_q.size(); i++) begin
      w = 0;
      while (o_tx !== 1'b0 && w < 5000) begin tick(); w++; end
      if (w >= 5000) begin
        checks++; errors++; $display("FAIL tx_timeout frame %0d got none want %h", i, exp_q[i]);
        break;
      end
      repeat ((b + 1) / 2) tick();
      f[0] = o_tx;
      for (int j = 1; j < 10; j++) begin
        repeat (b + 1) tick();
        f[j] = o_tx;
      end
      checks++;
      if (f !== {1'b1, exp_q[i], 1'b0}) begin
        errors++; $display("FAIL tx_frame %0d got %b want %b", i, f, {1'b1, exp_q[i], 1'b0});
      end
    end
  endtask

  task automatic test_tx_random();
    logic [7:0]  q[$];
    logic [15:0] v;
    int b, n;
    for (int r = 0; r < 3; r++) begin
      b = $urandom_range(1, 5);
      n = $urandom_range(1, 4);
      q = {};
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      wr(2'd3, 16'(b));
      fork
        for (int i = 0; i < n; i++) wr(2'd0, {8'($urandom), q[i]});
        decode_tx(b, q);
      join
      repeat (2 * (b + 1)) tick();
      rd(2'd1, v);
      checks++; if (v !== 16'h0004) begin errors++; $display("FAIL tx_rand_idle got %h want 0004", v); end
    end
  endtask

  task automatic test_tx_full();
    logic [7:0]  q[$];
    logic [15:0] v;
    logic        hi;
    q = {};
    for (int i = 0; i < 5; i++) q.push_back(8'($urandom));
    wr(2'd3, 16'd20);
    fork
      begin
        for (int i = 0; i < 5; i++) wr(2'd0, {8'h00, q[i]});
        rd(2'd1, v);
        checks++; if (v !== 16'h0002) begin errors++; $display("FAIL tx_full_status got %h want 0002", v); end
        wr(2'd0, 16'h00E7);
      end
      decode_tx(20, q);
    join
    hi = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (o_tx !== 1'b1) hi = 1'b0;
      tick();
    end
    checks++; if (hi !== 1'b1) begin errors++; $display("FAIL tx_drop got extra frame want idle line"); end
  endtask

  task automatic test_rx_basic();
    logic [15:0] v;
    wr(2'd3, 16'd3);
    send_rx(8'hA3, 3, 1'b1);
    rd(2'd1, v);
    checks++; if (v !== 16'h0005) begin errors++; $display("FAIL rx_avail got %h want 0005", v); end
    rd(2'd0, v);
    checks++; if (v !== 16'h00A3) begin errors++; $display("FAIL rx_data got %h want 00a3", v); end
    rd(2'd0, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL rx_empty_read got %h want 0000", v); end
    rd(2'd1, v);
    checks++; if (v !== 16'h0004) begin errors++; $display("FAIL rx_drained got %h want 0004", v); end
  endtask

  task automatic test_rx_random();
    logic [7:0]  q[$];
    logic [7:0]  d;
    logic [15:0] v, want;
    logic        ovr;
    int b, n;
    for (int r = 0; r < 4; r++) begin
      b = (r == 0) ? 3 : $urandom_range(1, 7);
      n = (r == 0) ? 5 : $urandom_range(1, 6);
      q = {}; ovr = 1'b0;
      wr(2'd3, 16'(b));
      for (int i = 0; i < n; i++) begin
        d = 8'($urandom);
        send_rx(d, b, 1'b1);
        if (q.size() < 4) q.push_back(d); else ovr = 1'b1;
      end
      rd(2'd1, v);
      want = {12'd0, ovr, 3'b101};
      checks++; if (v !== want) begin errors++; $display("FAIL rx_rand_status got %h want %h", v, want); end
      while (q.size() > 0) begin
        rd(2'd0, v);
        want = {8'h00, q.pop_front()};
        checks++; if (v !== want) begin errors++; $display("FAIL rx_rand_data got %h want %h", v, want); end
      end
      wr(2'd1, 16'h0008);
      rd(2'd1, v);
      checks++; if (v !== 16'h0004) begin errors++; $display("FAIL rx_ovr_clear got %h want 0004", v); end
    end
  endtask

  task automatic test_frame_err();
    logic [15:0] v;
    wr(2'd3, 16'd3);
    send_rx(8'($urandom), 3, 1'b0);
    rd(2'd1, v);
    checks++; if (v !== 16'h0014) begin errors++; $display("FAIL ferr_set got %h want 0014", v); end
    wr(2'd1, 16'h0010);
    rd(2'd1, v);
    checks++; if (v !== 16'h0004) begin errors++; $display("FAIL ferr_clear got %h want 0004", v); end
  endtask

  task automatic test_interrupt();
    logic [15:0] v;
    wr(2'd3, 16'd3);
    wr(2'd2, 16'h0002);
    tick();
    checks++; if (o_int !== 1'b1) begin errors++; $display("FAIL int_tx_idle got %b want 1", o_int); end
    wr(2'd0, 16'h0081);
    checks++; if (o_int !== 1'b0) begin errors++; $display("FAIL int_tx_busy got %b want 0", o_int); end
    repeat (30) tick();
    checks++; if (o_int !== 1'b0) begin errors++; $display("FAIL int_tx_mid got %b want 0", o_int); end
    repeat (20) tick();
    checks++; if (o_int !== 1'b1) begin errors++; $display("FAIL int_tx_done got %b want 1", o_int); end
    wr(2'd2, 16'h0001);
    tick();
    checks++; if (o_int !== 1'b0) begin errors++; $display("FAIL int_rx_none got %b want 0", o_int); end
    send_rx(8'h5A, 3, 1'b1);
    checks++; if (o_int !== 1'b1) begin errors++; $display("FAIL int_rx_avail got %b want 1", o_int); end
    rd(2'd0, v);
    tick();
    checks++; if (o_int !== 1'b0 || v !== 16'h005A) begin
      errors++; $display("FAIL int_rx_read got int %b data %h want 0 005a", o_int, v);
    end
    wr(2'd2, 16'h0000);
  endtask

  task automatic test_glitch();
    logic [15:0] v;
    wr(2'd3, 16'd7);
    i_rx = 1'b0;
    repeat (2) tick();
    i_rx = 1'b1;
    repeat (200) tick();
    rd(2'd1, v);
    checks++; if (v !== 16'h0004) begin errors++; $display("FAIL glitch got %h want 0004", v); end
  endtask

  task automatic test_loopback();
`ifdef DCPU_UART_LOOPBACK_EN
    logic [15:0] v;
    logic        hi;
    wr(2'd3, 16'd3);
    wr(2'd2, 16'h0004);
    i_rx = 1'b0;
    wr(2'd0, 16'h003C);
    hi = 1'b1;
    for (int k = 0; k < 80; k++) begin
      if (o_tx !== 1'b1) hi = 1'b0;
      tick();
    end
    checks++; if (hi !== 1'b1) begin errors++; $display("FAIL loop_tx got low want 1"); end
    rd(2'd0, v);
    checks++; if (v !== 16'h003C) begin errors++; $display("FAIL loop_data got %h want 003c", v); end
    i_rx = 1'b1;
    wr(2'd2, 16'h0000);
`endif
  endtask

  task automatic test_reset_abort();
    logic [15:0] v;
    logic        hi;
    wr(2'd3, 16'd3);
    wr(2'd0, 16'h00F0);
    repeat (2) tick();
    checks++; if (o_tx !== 1'b0) begin errors++; $display("FAIL abort_start got %b want 0", o_tx); end
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    checks++; if (o_tx !== 1'b1) begin errors++; $display("FAIL abort_tx got %b want 1", o_tx); end
    hi = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (o_tx !== 1'b1) hi = 1'b0;
      tick();
    end
    checks++; if (hi !== 1'b1) begin errors++; $display("FAIL abort_quiet got low want 1"); end
    rd(2'd3, v);
    checks++; if (v !== 16'd103) begin errors++; $display("FAIL abort_baud got %h want 0067", v); end
    rd(2'd1, v);
    checks++; if (v !== 16'h0004) begin errors++; $display("FAIL abort_status got %h want 0004", v); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_ctrl_baud();
    test_tx_pattern();
    test_tx_random();
    test_tx_full();
    test_rx_basic();
    test_rx_random();
    test_frame_err();
    test_interrupt();
    test_glitch();
    test_loopback();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
